// File: rtl/fir3_decim_filter.sv
// 3-tap signed FIR with a programmable arithmetic post-shift, output saturation and
// 1-in-(ratio+1) output decimation. Two register stages from sample accept to output strobe.
module fir3_decim_filter #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_conv_en,
    input  logic [DATA_W-1:0] I_coef0,
    input  logic [DATA_W-1:0] I_coef1,
    input  logic [DATA_W-1:0] I_coef2,
    input  logic [7:0]        I_coef_div,
    input  logic [1:0]        I_decimation_ratio,
    input  logic              I_in_valid,
    input  logic [DATA_W-1:0] I_in_data,
    output logic              O_out_valid,
    output logic [DATA_W-1:0] O_out_data,
    output logic              O_sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] x0_q, x1_q, x2_q, x0_d, x1_d, x2_d;
    logic signed [PROD_W-1:0] p0_q, p1_q, p2_q, p0_d, p1_d, p2_d;
    logic                     v0_q, v1_q, v0_d, v1_d;
    logic [1:0]               dcnt_q, dcnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     sat_q, sat_d;

    logic                     accept;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  q;
    logic [DATA_W-1:0]        clipped;
    logic                     clip_hit;
    logic                     emit;
    logic                     div_unused;

    // Only the low three bits select the shift amount.
    assign div_unused = ^I_coef_div[7:3];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        accept = I_in_valid && I_conv_en;

        x0_d = x0_q;
        x1_d = x1_q;
        x2_d = x2_q;
        if (!I_conv_en) begin
            x0_d = '0;
            x1_d = '0;
            x2_d = '0;
        end else if (accept) begin
            x0_d = I_in_data;
            x1_d = x0_q;
            x2_d = x1_q;
        end
        v0_d = accept;

        // Coefficients are sampled here, one edge after the sample entered the history.
        p0_d = PROD_W'($signed(I_coef0)) * PROD_W'(x0_q);
        p1_d = PROD_W'($signed(I_coef1)) * PROD_W'(x1_q);
        p2_d = PROD_W'($signed(I_coef2)) * PROD_W'(x2_q);
        v1_d = v0_q;

        acc = ACC_W'(p0_q) + ACC_W'(p1_q) + ACC_W'(p2_q);
        q   = acc >>> I_coef_div[2:0];
        clip_hit = 1'b1;
        if (q > SAT_MAX) begin
            clipped = SAT_MAX[DATA_W-1:0];
        end else if (q < SAT_MIN) begin
            clipped = SAT_MIN[DATA_W-1:0];
        end else begin
            clipped  = q[DATA_W-1:0];
            clip_hit = 1'b0;
        end

        // In-flight results still drain while disabled; the counter is held at zero then.
        emit = v1_q && ((dcnt_q == 2'd0) || !I_conv_en);

        dcnt_d = dcnt_q;
        if (!I_conv_en) begin
            dcnt_d = 2'd0;
        end else if (v1_q) begin
            dcnt_d = (dcnt_q >= I_decimation_ratio) ? 2'd0 : dcnt_q + 2'd1;
        end else if (dcnt_q > I_decimation_ratio) begin
            dcnt_d = 2'd0;
        end

        out_valid_d = emit;
        out_data_d  = emit ? clipped : out_data_q;
        sat_d       = sat_q || (emit && clip_hit);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            dcnt_q      <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            dcnt_q      <= dcnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    assign O_out_valid = out_valid_q;
    assign O_out_data  = out_data_q;
    assign O_sat       = sat_q;

endmodule

// File: tb/tb_fir3_decim_filter.sv
// Scoreboard bench for fir3_decim_filter: the driver queues hand-computed results with their
// due cycle, and a negedge monitor pops and compares on every output strobe.
module tb_fir3_decim_filter;

    typedef struct {
        logic signed [7:0] data;
        int                due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       I_conv_en = 1'b1;
    logic [7:0] I_coef0 = 8'd1;
    logic [7:0] I_coef1 = 8'd0;
    logic [7:0] I_coef2 = 8'd0;
    logic [7:0] I_coef_div = 8'd0;
    logic [1:0] I_decimation_ratio = 2'd0;
    logic       I_in_valid = 1'b0;
    logic [7:0] I_in_data = 8'd0;
    logic       O_out_valid;
    logic [7:0] O_out_data;
    logic       O_sat;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    fir3_decim_filter dut (
        .clk                (clk),
        .rst                (rst),
        .I_conv_en          (I_conv_en),
        .I_coef0            (I_coef0),
        .I_coef1            (I_coef1),
        .I_coef2            (I_coef2),
        .I_coef_div         (I_coef_div),
        .I_decimation_ratio (I_decimation_ratio),
        .I_in_valid         (I_in_valid),
        .I_in_data          (I_in_data),
        .O_out_valid        (O_out_valid),
        .O_out_data         (O_out_data),
        .O_sat              (O_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    endtask

    // Accept lands on the next posedge; the strobe is visible two edges later.
    task automatic send(input int d, input bit emit, input int want);
        @(negedge clk);
        I_in_valid = 1'b1;
        I_in_data  = 8'(d);
        if (emit) sb_q.push_back('{data: 8'(want), due: cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            I_in_valid = 1'b0;
        end
    endtask

    task automatic clear_history();
        I_conv_en = 1'b0;
        idle(1);
        I_conv_en = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (O_out_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_strobe", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", int'($signed(O_out_data)), int'(e.data));
                    check("latency", cyc, e.due);
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                check("missing_strobe", 0, int'(sb_q[0].data));
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        check("rst_out_valid", int'(O_out_valid), 0);
        check("rst_out_data", int'(O_out_data), 0);
        check("rst_sat", int'(O_sat), 0);
        rst = 1'b0;
        idle(2);

        // Pass-through with default taps.
        send(5, 1, 5);
        send(-7, 1, -7);
        send(100, 1, 100);
        idle(5);

        // Smoothing taps 1,2,1 with divide by 4.
        clear_history();
        I_coef0 = 8'd1; I_coef1 = 8'd2; I_coef2 = 8'd1; I_coef_div = 8'd2;
        send(4, 1, 1);
        send(4, 1, 3);
        send(4, 1, 4);
        send(4, 1, 4);
        idle(5);
        check("sat_clear_before_clip", int'(O_sat), 0);

        // Saturation at both rails.
        I_coef1 = 8'd0; I_coef2 = 8'd0; I_coef_div = 8'd0;
        I_coef0 = 8'd127;
        send(127, 1, 127);
        idle(4);
        I_coef0 = 8'h80;
        send(-128, 1, 127);
        idle(4);
        I_coef0 = 8'd127;
        send(-128, 1, -128);
        idle(5);
        check("sat_set", int'(O_sat), 1);

        // Arithmetic shift floors toward minus infinity.
        I_coef0 = 8'd1; I_coef_div = 8'd1;
        send(-3, 1, -2);
        send(3, 1, 1);
        idle(5);
        check("sat_sticky", int'(O_sat), 1);

        // Decimation by 3, then back to every result.
        I_coef_div = 8'd0; I_decimation_ratio = 2'd2;
        clear_history();
        for (int i = 1; i <= 9; i++) send(i, (i % 3) == 1, i);
        idle(5);
        I_decimation_ratio = 2'd0;
        send(10, 1, 10);
        send(11, 1, 11);
        send(12, 1, 12);
        idle(5);

        // Disabled samples are dropped; re-enable starts from zero history.
        I_conv_en = 1'b0;
        send(9, 0, 0);
        idle(1);
        send(-9, 0, 0);
        send(50, 0, 0);
        idle(5);
        I_conv_en = 1'b1;
        I_coef0 = 8'd1; I_coef1 = 8'd1; I_coef2 = 8'd1;
        send(6, 1, 6);
        send(6, 1, 12);
        send(6, 1, 18);
        idle(5);

        // Reset one cycle after an accept kills the in-flight result.
        send(6, 0, 0);
        @(negedge clk);
        I_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(O_out_valid), 0);
        check("midrst_out_data", int'(O_out_data), 0);
        check("midrst_sat", int'(O_sat), 0);
        idle(2);
        rst = 1'b0;
        idle(6);

        for (int t = 0; t < 20 && sb_q.size() > 0; t++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
